// File: rtl/dmem_arbiter_pkg.sv
// Shared types, funct3 encodings and the alignment rule for the data-memory arbiter.
// Loads and stores share funct3 encodings; only the low two bits select the access size.
package dmem_arb_pkg;

    localparam int DM_ADDRESS_DEF = 9;
    localparam int DATA_W_DEF     = 32;

    typedef enum logic {IDLE, ISSUE} arb_state_t;
    typedef enum logic {REQ_CORE, REQ_DBG} req_id_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte accesses and non-standard sizes (funct3[1:0]=11) are never flagged.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == F3_LW[1:0]) begin
            bad = (addr_lo != 2'b00);
        end else if (funct3[1:0] == F3_LH[1:0]) begin
            bad = addr_lo[0];
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the datamemory-facing signals of the arbiter.
// Handshake: a requester holds req and payload stable until it sees gnt in the same cycle;
// the response (rvalid, rdata, err) is a one-cycle pulse two cycles after gnt.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  c_req;
    logic                  c_we;
    logic [DM_ADDRESS-1:0] c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic [2:0]            c_funct3;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [DATA_W-1:0]     c_rdata;
    logic                  c_err;

    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [2:0]            d_funct3;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic                  dbg_lock;

    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [DATA_W-1:0]     rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        output d_gnt, d_rvalid, d_rdata, d_err,
        input  dbg_lock,
        output MemRead, MemWrite, a, wd, Funct3,
        input  rd
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        output dbg_lock,
        input  MemRead, MemWrite, a, wd, Funct3,
        output rd
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin picker; dbg_lock removes the core from eligibility.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic    c_req,
    input  logic    d_req,
    input  logic    lock,
    input  req_id_t rr_ptr,
    output logic    valid,
    output req_id_t winner,
    output logic    contended
);

    logic c_elig;

    always_comb begin
        c_elig    = c_req && !lock;
        valid     = c_elig || d_req;
        contended = c_elig && d_req;
        if (contended) begin
            winner = rr_ptr;
        end else if (c_elig) begin
            winner = REQ_CORE;
        end else begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants core or debug, issues one registered access per grant,
// returns a tagged registered response. Misaligned accesses are answered with err only.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_arbiter_if.slave bus,
    output arb_state_t dbg_state,
    output req_id_t    dbg_rr_ptr
);

    arb_state_t            state_q, state_d;
    req_id_t               rr_ptr_q, rr_ptr_d;
    req_id_t               id_q, id_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DM_ADDRESS-1:0] a_q, a_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [2:0]            f3_q, f3_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  c_rvalid_q, c_rvalid_d;
    logic                  c_err_q, c_err_d;
    logic [DATA_W-1:0]     c_rdata_q, c_rdata_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic                  d_err_q, d_err_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

    logic                  pick_valid;
    req_id_t               pick_id;
    logic                  pick_contended;
    logic                  grant;
    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [2:0]            sel_f3;
    logic                  sel_err;
    logic [DATA_W-1:0]     resp_data;

    dmem_rr_pick u_pick (
        .c_req     (bus.c_req),
        .d_req     (bus.d_req),
        .lock      (bus.dbg_lock),
        .rr_ptr    (rr_ptr_q),
        .valid     (pick_valid),
        .winner    (pick_id),
        .contended (pick_contended)
    );

    // Grant is combinational so a requester can drop req on the very next cycle.
    assign grant     = rst_n && (state_q == IDLE) && pick_valid;
    assign bus.c_gnt = grant && (pick_id == REQ_CORE);
    assign bus.d_gnt = grant && (pick_id == REQ_DBG);

    always_comb begin
        sel_we    = (pick_id == REQ_DBG) ? bus.d_we     : bus.c_we;
        sel_addr  = (pick_id == REQ_DBG) ? bus.d_addr   : bus.c_addr;
        sel_wdata = (pick_id == REQ_DBG) ? bus.d_wdata  : bus.c_wdata;
        sel_f3    = (pick_id == REQ_DBG) ? bus.d_funct3 : bus.c_funct3;
        sel_err   = is_misaligned(sel_f3, sel_addr[1:0]);
        resp_data = (!we_q && !err_q) ? bus.rd : '0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        we_d        = we_q;
        err_d       = err_q;
        a_d         = a_q;
        wd_d        = wd_q;
        f3_d        = f3_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        c_rvalid_d  = 1'b0;
        c_err_d     = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d     = ISSUE;
                    id_d        = pick_id;
                    we_d        = sel_we;
                    err_d       = sel_err;
                    a_d         = sel_addr;
                    wd_d        = sel_wdata;
                    f3_d        = sel_f3;
                    // Memory strobes are set up here so they are registered during ISSUE.
                    mem_read_d  = !sel_we && !sel_err;
                    mem_write_d = sel_we && !sel_err;
                    if (pick_contended) begin
                        rr_ptr_d = (pick_id == REQ_CORE) ? REQ_DBG : REQ_CORE;
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (id_q == REQ_CORE) begin
                    c_rvalid_d = 1'b1;
                    c_err_d    = err_q;
                    c_rdata_d  = resp_data;
                end else begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = err_q;
                    d_rdata_d  = resp_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= REQ_CORE;
            id_q        <= REQ_CORE;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            a_q         <= '0;
            wd_q        <= '0;
            f3_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            c_rvalid_q  <= 1'b0;
            c_err_q     <= 1'b0;
            c_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            err_q       <= err_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            f3_q        <= f3_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            c_rvalid_q  <= c_rvalid_d;
            c_err_q     <= c_err_d;
            c_rdata_q   <= c_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.a        = a_q;
    assign bus.wd       = wd_q;
    assign bus.Funct3   = f3_q;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.c_err    = c_err_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;
    assign dbg_state    = state_q;
    assign dbg_rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array datamemory model (mem[i] = i at start).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    arb_state_t dbg_state;
    req_id_t    dbg_rr_ptr;
    int         nv;
    int         nf;
    logic [7:0] mem [0:511];
    logic [31:0] exp_q [$];

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datamemory model: combinational read, write on the clock edge
    always_comb begin
        logic [8:0] ad;
        logic [7:0] b0, b1, b2, b3;
        ad = bus.a;
        b0 = mem[ad];
        b1 = mem[ad + 9'd1];
        b2 = mem[ad + 9'd2];
        b3 = mem[ad + 9'd3];
        case (bus.Funct3)
            3'b000:  bus.rd = {{24{b0[7]}}, b0};
            3'b001:  bus.rd = {{16{b1[7]}}, b1, b0};
            3'b010:  bus.rd = {b3, b2, b1, b0};
            3'b100:  bus.rd = {24'h0, b0};
            3'b101:  bus.rd = {16'h0, b1, b0};
            default: bus.rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.MemWrite) begin
            case (bus.Funct3)
                3'b000: mem[bus.a] = bus.wd[7:0];
                3'b001: begin
                    mem[bus.a]         = bus.wd[7:0];
                    mem[bus.a + 9'd1]  = bus.wd[15:8];
                end
                3'b010: begin
                    mem[bus.a]         = bus.wd[7:0];
                    mem[bus.a + 9'd1]  = bus.wd[15:8];
                    mem[bus.a + 9'd2]  = bus.wd[23:16];
                    mem[bus.a + 9'd3]  = bus.wd[31:24];
                end
                default: ;
            endcase
        end
    end

    // driver tasks
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic r, input logic we, input logic [8:0] ad, input logic [31:0] wd, input logic [2:0] f3);
        bus.c_req = r; bus.c_we = we; bus.c_addr = ad; bus.c_wdata = wd; bus.c_funct3 = f3;
    endtask

    task automatic set_dbg(input logic r, input logic we, input logic [8:0] ad, input logic [31:0] wd, input logic [2:0] f3);
        bus.d_req = r; bus.d_we = we; bus.d_addr = ad; bus.d_wdata = wd; bus.d_funct3 = f3;
    endtask

    task automatic idle_inputs;
        set_core(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        set_dbg(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        bus.dbg_lock = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // tests
    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        step();
        bus.c_req = 1'b1;
        step();
        #1;
        nv++; if (dbg_state !== IDLE) begin nf++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        nv++; if (dbg_rr_ptr !== REQ_CORE) begin nf++; $display("FAIL rst_rr_ptr: got %0d want %0d", dbg_rr_ptr, REQ_CORE); end
        nv++; if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0) begin nf++; $display("FAIL rst_memctl: got %0b%0b want 00", bus.MemRead, bus.MemWrite); end
        nv++; if (bus.a !== 9'h0 || bus.wd !== 32'h0 || bus.Funct3 !== 3'h0) begin nf++; $display("FAIL rst_membus: got a=%0h wd=%0h f3=%0h want 0 0 0", bus.a, bus.wd, bus.Funct3); end
        nv++; if (bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.c_err !== 1'b0 || bus.d_err !== 1'b0) begin nf++; $display("FAIL rst_resp: got rv=%0b%0b err=%0b%0b want 0000", bus.c_rvalid, bus.d_rvalid, bus.c_err, bus.d_err); end
        nv++; if (bus.c_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin nf++; $display("FAIL rst_rdata: got %0h %0h want 0 0", bus.c_rdata, bus.d_rdata); end
        nv++; if (bus.c_gnt !== 1'b0) begin nf++; $display("FAIL rst_gnt: got %0b want 0", bus.c_gnt); end
        bus.c_req = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_core_read;
        apply_reset();
        set_core(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        #1;
        nv++; if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin nf++; $display("FAIL crd_gnt: got c=%0b d=%0b want c=1 d=0", bus.c_gnt, bus.d_gnt); end
        step();
        bus.c_req = 1'b0;
        #1;
        nv++; if (bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0) begin nf++; $display("FAIL crd_memctl: got %0b%0b want 10", bus.MemRead, bus.MemWrite); end
        nv++; if (bus.a !== 9'h010 || bus.Funct3 !== F3_LW) begin nf++; $display("FAIL crd_addr: got a=%0h f3=%0h want 10 2", bus.a, bus.Funct3); end
        nv++; if (bus.c_rvalid !== 1'b0) begin nf++; $display("FAIL crd_early_rvalid: got %0b want 0", bus.c_rvalid); end
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h13121110 || bus.c_err !== 1'b0) begin nf++; $display("FAIL crd_resp: got rv=%0b data=%0h err=%0b want 1 13121110 0", bus.c_rvalid, bus.c_rdata, bus.c_err); end
        nv++; if (bus.d_rvalid !== 1'b0 || bus.MemRead !== 1'b0) begin nf++; $display("FAIL crd_quiet: got d_rv=%0b MemRead=%0b want 0 0", bus.d_rvalid, bus.MemRead); end
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'h13121110) begin nf++; $display("FAIL crd_hold: got rv=%0b data=%0h want 0 13121110", bus.c_rvalid, bus.c_rdata); end
    endtask

    task automatic test_back_to_back;
        int w;
        int pw;
        logic [31:0] exp;
        logic [31:0] got;
        apply_reset();
        exp_q.delete();
        set_core(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        set_dbg(1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        for (int cyc = 0; cyc <= 8; cyc++) begin
            if (cyc == 7) begin
                bus.c_req = 1'b0;
                bus.d_req = 1'b0;
            end
            #1;
            if (cyc % 2 == 0) begin
                if (cyc >= 2) begin
                    pw = ((cyc - 2) / 2) % 2;
                    nv++; if (bus.c_rvalid !== (pw == 0) || bus.d_rvalid !== (pw == 1)) begin nf++; $display("FAIL b2b_rvalid cyc%0d: got c=%0b d=%0b want side %0d", cyc, bus.c_rvalid, bus.d_rvalid, pw); end
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                    got = (pw == 1) ? bus.d_rdata : bus.c_rdata;
                    nv++; if (got !== exp) begin nf++; $display("FAIL b2b_rdata cyc%0d: got %0h want %0h", cyc, got, exp); end
                end
                if (cyc < 8) begin
                    w = (cyc / 2) % 2;
                    nv++; if (bus.c_gnt !== (w == 0) || bus.d_gnt !== (w == 1)) begin nf++; $display("FAIL b2b_gnt cyc%0d: got c=%0b d=%0b want side %0d", cyc, bus.c_gnt, bus.d_gnt, w); end
                    exp_q.push_back((w == 1) ? 32'h23222120 : 32'h13121110);
                end else begin
                    nv++; if (bus.c_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin nf++; $display("FAIL b2b_no_gnt: got c=%0b d=%0b want 0 0", bus.c_gnt, bus.d_gnt); end
                end
            end else begin
                nv++; if (bus.c_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin nf++; $display("FAIL b2b_issue_gnt cyc%0d: got c=%0b d=%0b want 0 0", cyc, bus.c_gnt, bus.d_gnt); end
            end
            step();
        end
        nv++; if (exp_q.size() != 0) begin nf++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_lock;
        apply_reset();
        bus.dbg_lock = 1'b1;
        set_core(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        set_dbg(1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 7) bus.dbg_lock = 1'b0;
            if (cyc == 9) begin
                bus.dbg_lock = 1'b1;
                bus.c_req = 1'b0;
                bus.d_req = 1'b0;
            end
            #1;
            if (cyc == 0 || cyc == 2 || cyc == 4 || cyc == 6) begin
                nv++; if (bus.d_gnt !== 1'b1 || bus.c_gnt !== 1'b0) begin nf++; $display("FAIL lock_gnt cyc%0d: got c=%0b d=%0b want c=0 d=1", cyc, bus.c_gnt, bus.d_gnt); end
            end
            if (cyc == 8) begin
                nv++; if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin nf++; $display("FAIL unlock_gnt: got c=%0b d=%0b want c=1 d=0", bus.c_gnt, bus.d_gnt); end
                nv++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h23222120) begin nf++; $display("FAIL lock_dresp: got rv=%0b data=%0h want 1 23222120", bus.d_rvalid, bus.d_rdata); end
            end
            if (cyc == 10) begin
                nv++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h13121110) begin nf++; $display("FAIL lock_inflight: got rv=%0b data=%0h want 1 13121110", bus.c_rvalid, bus.c_rdata); end
            end
            step();
        end
        bus.dbg_lock = 1'b0;
    endtask

    task automatic test_reset_mid;
        #1;
        nv++; if (dbg_rr_ptr !== REQ_DBG) begin nf++; $display("FAIL mid_pre_ptr: got %0d want %0d", dbg_rr_ptr, REQ_DBG); end
        set_core(1'b1, 1'b1, 9'h008, 32'h11223344, F3_SW);
        #1;
        nv++; if (bus.c_gnt !== 1'b1) begin nf++; $display("FAIL mid_gnt: got %0b want 1", bus.c_gnt); end
        step();
        bus.c_req = 1'b0;
        #1;
        nv++; if (bus.MemWrite !== 1'b1 || bus.a !== 9'h008) begin nf++; $display("FAIL mid_issue: got we=%0b a=%0h want 1 8", bus.MemWrite, bus.a); end
        rst_n = 1'b0;
        step();
        #1;
        nv++; if (bus.MemWrite !== 1'b0 || bus.c_rvalid !== 1'b0) begin nf++; $display("FAIL mid_abandon: got we=%0b rv=%0b want 0 0", bus.MemWrite, bus.c_rvalid); end
        nv++; if (dbg_state !== IDLE || dbg_rr_ptr !== REQ_CORE) begin nf++; $display("FAIL mid_state: got st=%0d ptr=%0d want 0 0", dbg_state, dbg_rr_ptr); end
        nv++; if (bus.d_rdata !== 32'h0) begin nf++; $display("FAIL mid_rdata_clr: got %0h want 0", bus.d_rdata); end
        rst_n = 1'b1;
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b0) begin nf++; $display("FAIL mid_late_rvalid: got %0b want 0", bus.c_rvalid); end
        step();
    endtask

    task automatic test_misaligned;
        apply_reset();
        set_core(1'b1, 1'b1, 9'h006, 32'hDEADBEEF, F3_SW);
        #1;
        nv++; if (bus.c_gnt !== 1'b1) begin nf++; $display("FAIL mis_sw_gnt: got %0b want 1", bus.c_gnt); end
        step();
        bus.c_req = 1'b0;
        #1;
        nv++; if (bus.MemWrite !== 1'b0 || bus.MemRead !== 1'b0) begin nf++; $display("FAIL mis_sw_memctl: got %0b%0b want 00", bus.MemRead, bus.MemWrite); end
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_err !== 1'b1 || bus.c_rdata !== 32'h0) begin nf++; $display("FAIL mis_sw_resp: got rv=%0b err=%0b data=%0h want 1 1 0", bus.c_rvalid, bus.c_err, bus.c_rdata); end
        nv++; if ({mem[7], mem[6], mem[5], mem[4]} !== 32'h07060504) begin nf++; $display("FAIL mis_sw_mem: got %0h want 07060504", {mem[7], mem[6], mem[5], mem[4]}); end
        set_core(1'b1, 1'b0, 9'h011, 32'h0, F3_LH);
        step();
        bus.c_req = 1'b0;
        #1;
        nv++; if (bus.MemRead !== 1'b0) begin nf++; $display("FAIL mis_lh_memread: got %0b want 0", bus.MemRead); end
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_err !== 1'b1) begin nf++; $display("FAIL mis_lh_resp: got rv=%0b err=%0b want 1 1", bus.c_rvalid, bus.c_err); end
        set_core(1'b1, 1'b0, 9'h001, 32'h0, 3'b011);
        step();
        bus.c_req = 1'b0;
        #1;
        nv++; if (bus.MemRead !== 1'b1 || bus.Funct3 !== 3'b011) begin nf++; $display("FAIL inv_f3_issue: got rd=%0b f3=%0h want 1 3", bus.MemRead, bus.Funct3); end
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_err !== 1'b0) begin nf++; $display("FAIL inv_f3_resp: got rv=%0b err=%0b want 1 0", bus.c_rvalid, bus.c_err); end
    endtask

    task automatic test_store_load;
        apply_reset();
        set_dbg(1'b1, 1'b1, 9'h003, 32'h000000AB, F3_SB);
        #1;
        nv++; if (bus.d_gnt !== 1'b1 || bus.c_gnt !== 1'b0) begin nf++; $display("FAIL sb_gnt: got d=%0b c=%0b want 1 0", bus.d_gnt, bus.c_gnt); end
        step();
        bus.d_req = 1'b0;
        #1;
        nv++; if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.a !== 9'h003 || bus.wd !== 32'h000000AB || bus.Funct3 !== F3_SB) begin nf++; $display("FAIL sb_issue: got we=%0b re=%0b a=%0h wd=%0h f3=%0h want 1 0 3 ab 0", bus.MemWrite, bus.MemRead, bus.a, bus.wd, bus.Funct3); end
        step();
        #1;
        nv++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0) begin nf++; $display("FAIL sb_resp: got rv=%0b err=%0b data=%0h want 1 0 0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
        set_core(1'b1, 1'b0, 9'h003, 32'h0, F3_LBU);
        #1;
        nv++; if (bus.c_gnt !== 1'b1) begin nf++; $display("FAIL lbu_gnt: got %0b want 1", bus.c_gnt); end
        step();
        bus.c_req = 1'b0;
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h000000AB || bus.c_err !== 1'b0 || bus.d_rvalid !== 1'b0) begin nf++; $display("FAIL lbu_resp: got rv=%0b data=%0h err=%0b drv=%0b want 1 ab 0 0", bus.c_rvalid, bus.c_rdata, bus.c_err, bus.d_rvalid); end
        set_core(1'b1, 1'b0, 9'h003, 32'h0, F3_LB);
        step();
        bus.c_req = 1'b0;
        step();
        #1;
        nv++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hFFFFFFAB) begin nf++; $display("FAIL lb_resp: got rv=%0b data=%0h want 1 ffffffab", bus.c_rvalid, bus.c_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = i[7:0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nv = 0;
        nf = 0;
        rst_n = 1'b0;
        idle_inputs();
        step();
        test_reset();
        test_core_read();
        test_back_to_back();
        test_lock();
        test_reset_mid();
        test_misaligned();
        test_store_load();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (core, "c_") and the debug/program-load port (debug, "d_").
- Grants one requester at a time, round-robin, with an optional debug lock. Issues one registered access per grant and returns a registered, tagged response to the winner.
- Rejects misaligned accesses with an error response; these never reach memory.
- Sits between the MEM stage / debug loader and datamemory. It drives that block's MemRead, MemWrite, a, wd and Funct3, and samples its rd.

Parameters:
- DM_ADDRESS, 9, data-memory address width in bytes.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  DM_ADDRESS  core byte address
- c_wdata  in  DATA_W  core store data
- c_funct3  in  3  core access size/sign (RISC-V funct3)
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core response valid (one cycle)
- c_rdata  out  DATA_W  core load data
- c_err  out  1  core misaligned access, qualified by c_rvalid
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata, d_err  same as the c_ ports, for debug
- dbg_lock  in  1  while high, core is never granted
- MemRead  out  1  to datamemory
- MemWrite  out  1  to datamemory
- a  out  DM_ADDRESS  to datamemory
- wd  out  DATA_W  to datamemory
- Funct3  out  3  to datamemory
- rd  in  DATA_W  from datamemory (combinational read data)

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active low, on rst_n.
- Reset values: state=IDLE; MemRead=MemWrite=0; a=0; wd=0; Funct3=0; all gnt/rvalid/err=0; rdata=0; rr_ptr=core.
- FSM IDLE:
  - Eligible requesters: c_req (only when dbg_lock=0) and d_req.
  - One eligible requester: it wins.
  - Both eligible: the side given by rr_ptr wins, and rr_ptr flips to the other side on that grant.
  - gnt is combinational, asserted only in IDLE, to the winner only.
  - On grant, latch we/addr/wdata/funct3 and the winner id into the issue registers, then go to ISSUE.
- Alignment check, done at grant:
  - Word (funct3[1:0]=10) needs addr[1:0]=00.
  - Half (funct3[1:0]=01) needs addr[0]=0.
  - Byte is always aligned.
  - Misaligned: mark err, keep MemRead/MemWrite at 0 in ISSUE.
- FSM ISSUE (one cycle):
  - Drive a/wd/Funct3 from the issue registers.
  - MemRead = !we & !err; MemWrite = we & !err.
  - At the end of the cycle, capture rd into the winner's rdata (reads only; writes and errors capture 0).
  - Set winner rvalid and err for the next cycle. Next state is IDLE.
- Response: rvalid is high exactly one cycle, the cycle after ISSUE (latency grant→rvalid = 2 cycles). The other side's rvalid stays 0.
- rdata holding: rdata holds its value until the next response to the same side.
- Memory control: MemRead and MemWrite are registered, never both high, and high only in ISSUE.
- Throughput: one access per 2 cycles. A request held through ISSUE is re-arbitrated in the following IDLE.
- dbg_lock:
  - Rising while core is in ISSUE: core access completes normally.
  - Lock only blocks new core grants.
- Requester obligation: hold req and payload stable until gnt is seen.
- Reset mid-operation: an access in ISSUE is abandoned. MemWrite deasserts on the reset cycle's edge and no rvalid is produced.
- Invalid funct3 (e.g. 3'b011, 3'b111): passed through unchanged. datamemory's default handling applies; no err.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum {IDLE, ISSUE} arb_state_t
  - typedef enum logic {REQ_CORE, REQ_DBG} req_id_t
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - function is_misaligned(funct3, addr[1:0])
- Sub-module dmem_rr_pick (2-way round-robin picker with lock masking). It is natural and independently testable; the rest stays in dmem_arbiter.

Test Plan:
- Core only, LW addr=0x010 → c_gnt in cycle 0; MemRead=1, a=0x010 in cycle 1; c_rvalid=1 with c_rdata=mem[0x010] in cycle 2; d_rvalid stays 0.
- c_req and d_req both held continuously after reset → grants alternate core, debug, core, debug, each 2 cycles apart; each side receives its own rdata.
- dbg_lock=1 with both requesting → only d_gnt for 4 consecutive grants. Drop the lock → the next grant goes to core.
- Core SW addr=0x006 (misaligned) → c_gnt; MemWrite stays 0 in ISSUE; c_rvalid=1, c_err=1; memory contents unchanged.
- Debug SB addr=0x003 wd=0xAB, then core LBU addr=0x003 → core receives c_rdata=0x000000AB, c_err=0.
- rst_n=0 during ISSUE of a core SW → MemWrite=0 on the next cycle; no c_rvalid; state IDLE; rr_ptr=core.
